// File: rtl/max_pool_seq_pkg.sv
// Shared CNN package: default sizes, pooling FSM states, lane vector type and window clamp.
package max_pool_seq_pkg;

   localparam int unsigned DEF_LANES   = 32;
   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_MAX_WIN = 16;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StHold
   } state_e;

   typedef logic signed [DEF_WIDTH-1:0] lane_vec_t [DEF_LANES];

   // Window length 0 means 1; anything beyond the configured maximum saturates to it.
   function automatic logic [4:0] clamp_win(input logic [4:0] cfg, input logic [4:0] max_win);
      if (cfg == 5'd0) begin
         return 5'd1;
      end else if (cfg > max_win) begin
         return max_win;
      end else begin
         return cfg;
      end
   endfunction

endpackage

// File: rtl/max_lane_acc.sv
// One lane of the pooling accumulator: loads on a window's first beat, keeps the signed maximum.
module max_lane_acc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic                    update,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] din,
   output logic signed [WIDTH-1:0] acc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (load) begin
         acc <= en ? din : '0;
      end else if (update && en && (din > acc)) begin
         acc <= din;
      end
   end

endmodule

// File: rtl/max_pool_seq.sv
// Sequential per-lane max pooling over a window of beats.
// Define MAX_POOL_SEQ_OVERLAP_EN to accept the next window's first beat while a result is taken.
module max_pool_seq
   import max_pool_seq_pkg::*;
#(
   parameter int unsigned LANES   = DEF_LANES,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned MAX_WIN = DEF_MAX_WIN
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4:0]              cfg_win,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data [LANES],
   input  logic [LANES-1:0]        in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_data [LANES],
   output logic                    busy
);

   state_e           state;
   logic [4:0]       count;
   logic [4:0]       win_q;
   logic [4:0]       win_new;
   logic [LANES-1:0] mask_q;
   logic             beat;
   logic             load;
   logic             update;

   always_comb begin
      win_new = clamp_win(cfg_win, 5'(MAX_WIN));
`ifdef MAX_POOL_SEQ_OVERLAP_EN
      in_ready = (state == StHold) ? out_ready : 1'b1;
`else
      in_ready = (state != StHold);
`endif
      beat   = in_valid & in_ready;
      // A beat outside ACCUM always opens a new window.
      load   = beat & (state != StAccum);
      update = beat & (state == StAccum);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         count     <= 5'd0;
         win_q     <= 5'd1;
         mask_q    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (beat) begin
                  win_q     <= win_new;
                  mask_q    <= in_mask;
                  count     <= 5'd1;
                  busy      <= 1'b1;
                  out_valid <= (win_new == 5'd1);
                  state     <= (win_new == 5'd1) ? StHold : StAccum;
               end
            end
            StAccum: begin
               if (beat) begin
                  count <= count + 5'd1;
                  if ((count + 5'd1) == win_q) begin
                     out_valid <= 1'b1;
                     state     <= StHold;
                  end
               end
            end
            StHold: begin
               if (out_ready) begin
                  if (beat) begin
                     win_q     <= win_new;
                     mask_q    <= in_mask;
                     count     <= 5'd1;
                     busy      <= 1'b1;
                     out_valid <= (win_new == 5'd1);
                     state     <= (win_new == 5'd1) ? StHold : StAccum;
                  end else begin
                     count     <= 5'd0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     state     <= StIdle;
                  end
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      max_lane_acc #(
         .WIDTH(WIDTH)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .update(update),
         .en    (load ? in_mask[i] : mask_q[i]),
         .din   (in_data[i]),
         .acc   (out_data[i])
      );
   end

endmodule

// File: tb/tb_max_pool_seq.sv
// Directed bench for max_pool_seq; covers MAX_POOL_SEQ_OVERLAP_EN builds as well.
module tb_max_pool_seq;
   import max_pool_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] cfg_win;
   logic       in_valid;
   logic       in_ready;
   lane_vec_t  in_data;
   logic [31:0] in_mask;
   logic       out_valid;
   logic       out_ready;
   lane_vec_t  out_data;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   max_pool_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_win  (cfg_win),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mask  (in_mask),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic signed [31:0] v);
      for (int i = 0; i < 32; i++) in_data[i] = v;
   endtask

   // Take the held result and return to IDLE.
   task automatic consume();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_win   = 5'd4;
      in_valid  = 1'b0;
      in_mask   = 32'hFFFF_FFFF;
      out_ready = 1'b0;
      fill(32'sd0);
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data0", out_data[0], 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Window of 4: lane0 3,-7,9,2 -> 9; lane7 1..4 -> 4. Config changes mid-window ignored.
      fill(32'sd0);
      in_data[0] = 32'sd3;  in_data[7] = 32'sd1;
      in_valid = 1'b1;
      tick();
      chk("w4_busy_b1", {31'd0, busy}, 32'd1);
      chk("w4_ov_b1", {31'd0, out_valid}, 32'd0);
      cfg_win = 5'd1;
      in_mask = 32'h0;
      in_data[0] = -32'sd7; in_data[7] = 32'sd2;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("w4_stall_ov", {31'd0, out_valid}, 32'd0);
      chk("w4_stall_busy", {31'd0, busy}, 32'd1);
      in_valid = 1'b1;
      in_data[0] = 32'sd9;  in_data[7] = 32'sd3;
      tick();
      chk("w4_ov_b3", {31'd0, out_valid}, 32'd0);
      in_data[0] = 32'sd2;  in_data[7] = 32'sd4;
      tick();
      in_valid = 1'b0;
      chk("w4_ov", {31'd0, out_valid}, 32'd1);
      chk("w4_lane0", out_data[0], 32'd9);
      chk("w4_lane7", out_data[7], 32'd4);
      chk("w4_lane3", out_data[3], 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_ov", {31'd0, out_valid}, 32'd1);
         chk("hold_data", out_data[0], 32'd9);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      consume();
      chk("xfer_ov", {31'd0, out_valid}, 32'd0);
      chk("xfer_busy", {31'd0, busy}, 32'd0);

      // Signed window of 2: lane5 -8,-3 -> -3; lane0 equal operands 5,5 -> 5.
      cfg_win = 5'd2;
      in_mask = 32'hFFFF_FFFF;
      fill(-32'sd100);
      in_data[5] = -32'sd8; in_data[0] = 32'sd5;
      in_valid = 1'b1;
      tick();
      in_data[5] = -32'sd3;
      tick();
      in_valid = 1'b0;
      chk("sgn_ov", {31'd0, out_valid}, 32'd1);
      chk("sgn_lane5", out_data[5], 32'hFFFF_FFFD);
      chk("sgn_lane0_eq", out_data[0], 32'd5);
      chk("sgn_lane9", out_data[9], 32'hFFFF_FF9C);
      consume();

      // Mask only lane0, window of 3: lane0 -5,-1,-9 -> -1; other lanes forced 0.
      cfg_win = 5'd3;
      in_mask = 32'h0000_0001;
      fill(32'sd77);
      in_data[0] = -32'sd5;
      in_valid = 1'b1;
      tick();
      in_data[0] = -32'sd1;
      tick();
      in_data[0] = -32'sd9;
      tick();
      in_valid = 1'b0;
      chk("msk_ov", {31'd0, out_valid}, 32'd1);
      chk("msk_lane0", out_data[0], 32'hFFFF_FFFF);
      chk("msk_lane1", out_data[1], 32'd0);
      chk("msk_lane31", out_data[31], 32'd0);
      consume();

      // cfg_win=0 acts as 1.
      cfg_win = 5'd0;
      in_mask = 32'hFFFF_FFFF;
      fill(32'sd42);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("w0_ov", {31'd0, out_valid}, 32'd1);
      chk("w0_data", out_data[0], 32'd42);
      consume();

      // cfg_win=20 clamps to 16.
      cfg_win = 5'd20;
      in_valid = 1'b1;
      for (int b = 0; b < 16; b++) begin
         fill((b == 10) ? 32'sd1000 : 32'(b));
         tick();
         if (b == 14) chk("w20_ov_15", {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      chk("w20_ov_16", {31'd0, out_valid}, 32'd1);
      chk("w20_data", out_data[0], 32'd1000);
      consume();

      // Reset mid-window discards the partial result.
      cfg_win = 5'd4;
      in_valid = 1'b1;
      fill(32'sd500);
      tick();
      fill(32'sd600);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("mrst_ov", {31'd0, out_valid}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_data", out_data[0], 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b1;
      for (int b = 1; b <= 4; b++) begin
         fill(32'(b));
         tick();
      end
      in_valid = 1'b0;
      chk("post_rst_ov", {31'd0, out_valid}, 32'd1);
      chk("post_rst_data", out_data[0], 32'd4);
      consume();

`ifdef MAX_POOL_SEQ_OVERLAP_EN
      // Back-to-back windows of 2 with zero bubble: results 2, 4, 6.
      cfg_win = 5'd2;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int b = 1; b <= 6; b++) begin
         fill(32'(b));
         tick();
         if (b % 2 == 0) begin
            chk("ovl_ov", {31'd0, out_valid}, 32'd1);
            chk("ovl_data", out_data[0], 32'(b));
         end else if (b > 1) begin
            chk("ovl_gap", {31'd0, out_valid}, 32'd0);
         end
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
`else
      // One-cycle bubble: a beat offered during result transfer is not taken.
      cfg_win = 5'd1;
      in_valid = 1'b1;
      fill(32'sd11);
      tick();
      chk("bub_ov", {31'd0, out_valid}, 32'd1);
      chk("bub_data", out_data[0], 32'd11);
      fill(32'sd22);
      out_ready = 1'b1;
      tick();
      chk("bub_idle_ov", {31'd0, out_valid}, 32'd0);
      chk("bub_idle_busy", {31'd0, busy}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bub_next_ov", {31'd0, out_valid}, 32'd1);
      chk("bub_next_data", out_data[0], 32'd22);
      tick();
      out_ready = 1'b0;
`endif
      chk("end_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
